fpmul_credit_sink: RTL and testbench

// - Receiving end of the fpmul push interface (pushout/r). fpmul has no backpressure, so this block

---
 rtl/fpmul_credit_sink_if.sv | 29 ++
 rtl/fpmul_credit_sink.sv | 100 ++++++++++
 tb/tb_fpmul_credit_sink.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fpmul_credit_sink_if.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_credit_sink_if
// Description : Issue/return handshake from fpmul plus the drain stream toward
//               the downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpmul_credit_sink_if #(
    parameter int WIDTH = 64
);
    logic             mul_pushin;
    logic             issue_ok;
    logic             mul_push;
    logic [WIDTH-1:0] mul_r;
    logic             pushout;
    logic [WIDTH-1:0] r;
    logic             stopin;

    modport master (
        output mul_pushin, mul_push, mul_r, stopin,
        input  issue_ok, pushout, r
    );

    modport slave (
        input  mul_pushin, mul_push, mul_r, stopin,
        output issue_ok, pushout, r
    );
endinterface
`default_nettype wire

// File: rtl/fpmul_credit_sink.sv
`default_nettype none
// ============================================================================
// Module      : fpmul_credit_sink
// Description : Credit-managed result FIFO behind fpmul, which cannot stall.
// Revision    : 1.0 - initial release
// ============================================================================
module fpmul_credit_sink #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16,
    parameter int LAT   = 9
) (
    input  wire logic                clk,
    input  wire logic                rst,
    fpmul_credit_sink_if.slave       bus,
    output logic                     credit_err
);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (LAT < 1)) begin : g_bad_param
        $error("fpmul_credit_sink: DEPTH must be a power of 2 >= 2 and LAT >= 1");
    end

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] r_inflight;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic               r_credit_err;

    logic               w_pushout;
    logic               w_read;
    logic               w_full;
    logic               w_wr;
    logic               w_drop;
    logic               w_ret;
    logic               w_err_a;
    logic               w_err_b;
    logic               w_issue_ok;
    logic [c_cnt_w:0]   w_committed;

    // Credits cover both stored entries and products still inside fpmul.
    assign w_committed = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_issue_ok  = w_committed < {1'b0, c_depth};

    always_comb begin
        w_pushout = (r_count != '0);
        w_read    = w_pushout & ~bus.stopin;
        w_full    = (r_count == c_depth);
        w_wr      = bus.mul_push & (~w_full | w_read);
        w_drop    = bus.mul_push & w_full & ~w_read;
        w_ret     = bus.mul_push & (r_inflight != '0);
        w_err_a   = bus.mul_pushin & ~w_issue_ok;
        w_err_b   = bus.mul_push & (r_inflight == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_inflight   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_credit_err <= 1'b0;
        end else begin
            case ({w_wr, w_read})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // An over-issue still counts, but never beyond DEPTH.
            if (bus.mul_pushin && !w_ret && (r_inflight != c_depth)) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!bus.mul_pushin && w_ret) begin
                r_inflight <= r_inflight - 1'b1;
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_err_a || w_err_b || w_drop) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            mem[r_wr_ptr] <= bus.mul_r;
        end
    end

    assign bus.pushout  = w_pushout;
    assign bus.r        = w_pushout ? mem[r_rd_ptr] : '0;
    assign bus.issue_ok = w_issue_ok;
    assign credit_err   = r_credit_err;
endmodule
`default_nettype wire

// File: tb/tb_fpmul_credit_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpmul_credit_sink
// Description : Directed self-checking bench for fpmul_credit_sink.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpmul_credit_sink;
    localparam int WIDTH = 64;
    localparam int DEPTH = 16;
    localparam int LAT   = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic credit_err;
    int   checks = 0;
    int   fails  = 0;

    fpmul_credit_sink_if #(.WIDTH(WIDTH)) bus ();

    fpmul_credit_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.mul_pushin = 1'b0;
        bus.mul_push   = 1'b0;
        bus.mul_r      = '0;
        bus.stopin     = 1'b0;
        rst            = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.pushout !== 1'b0) begin fails++; $display("FAIL reset_pushout: got %b expected 0", bus.pushout); end
        checks++; if (bus.r !== 64'h0) begin fails++; $display("FAIL reset_r: got %h expected 0", bus.r); end
        checks++; if (bus.issue_ok !== 1'b1) begin fails++; $display("FAIL reset_issue_ok: got %b expected 1", bus.issue_ok); end
        checks++; if (credit_err !== 1'b0) begin fails++; $display("FAIL reset_credit_err: got %b expected 0", credit_err); end
    endtask

    task automatic test_single_pass();
        bus.stopin     = 1'b0;
        bus.mul_pushin = 1'b1;
        step();
        bus.mul_pushin = 1'b0;
        checks++; if (bus.pushout !== 1'b0) begin fails++; $display("FAIL single_early_pushout: got %b expected 0", bus.pushout); end
        repeat (LAT - 1) step();
        bus.mul_push = 1'b1;
        bus.mul_r    = 64'h3FF0_0000_0000_0000;
        step();
        bus.mul_push = 1'b0;
        checks++; if (bus.pushout !== 1'b1) begin fails++; $display("FAIL single_pushout: got %b expected 1", bus.pushout); end
        checks++; if (bus.r !== 64'h3FF0_0000_0000_0000) begin fails++; $display("FAIL single_r: got %h expected 3ff0000000000000", bus.r); end
        step();
        checks++; if (bus.pushout !== 1'b0) begin fails++; $display("FAIL single_drained: got %b expected 0", bus.pushout); end
        checks++; if (bus.r !== 64'h0) begin fails++; $display("FAIL single_r_empty: got %h expected 0", bus.r); end
        checks++; if (credit_err !== 1'b0) begin fails++; $display("FAIL single_credit_err: got %b expected 0", credit_err); end
    endtask

    task automatic test_credit_exhaustion();
        bus.stopin = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.issue_ok !== 1'b1) begin fails++; $display("FAIL exhaust_issue_ok_%0d: got %b expected 1", i, bus.issue_ok); end
            bus.mul_pushin = 1'b1;
            step();
        end
        bus.mul_pushin = 1'b0;
        checks++; if (bus.issue_ok !== 1'b0) begin fails++; $display("FAIL exhaust_issue_ok_full: got %b expected 0", bus.issue_ok); end
        for (int i = 0; i < DEPTH; i++) begin
            bus.mul_push = 1'b1;
            bus.mul_r    = 64'(100 + i);
            step();
        end
        bus.mul_push = 1'b0;
        checks++; if (bus.issue_ok !== 1'b0) begin fails++; $display("FAIL exhaust_issue_ok_stored: got %b expected 0", bus.issue_ok); end
        checks++; if (bus.pushout !== 1'b1) begin fails++; $display("FAIL exhaust_pushout: got %b expected 1", bus.pushout); end
        checks++; if (bus.r !== 64'd100) begin fails++; $display("FAIL exhaust_head: got %0d expected 100", bus.r); end
        bus.stopin = 1'b0;
        step();
        bus.stopin = 1'b1;
        checks++; if (bus.issue_ok !== 1'b1) begin fails++; $display("FAIL exhaust_issue_ok_after_drain: got %b expected 1", bus.issue_ok); end
        for (int i = 1; i < DEPTH; i++) begin
            checks++; if (bus.r !== 64'(100 + i)) begin fails++; $display("FAIL exhaust_order_%0d: got %0d expected %0d", i, bus.r, 100 + i); end
            bus.stopin = 1'b0;
            step();
        end
        checks++; if (bus.pushout !== 1'b0) begin fails++; $display("FAIL exhaust_empty: got %b expected 0", bus.pushout); end
        checks++; if (credit_err !== 1'b0) begin fails++; $display("FAIL exhaust_credit_err: got %b expected 0", credit_err); end
    endtask

    task automatic test_wrap_order();
        int          due[$];
        logic [63:0] vals[$];
        int          issued = 0;
        int          nexp   = 0;
        int          cyc    = 0;
        while (nexp < 40 && cyc < 2000) begin
            bus.stopin     = 1'($urandom_range(0, 1));
            bus.mul_pushin = bus.issue_ok && (issued < 40);
            if (bus.mul_pushin) begin
                due.push_back(cyc + LAT);
                vals.push_back(64'(issued));
                issued++;
            end
            bus.mul_push = 1'b0;
            if (due.size() > 0 && due[0] == cyc) begin
                bus.mul_push = 1'b1;
                bus.mul_r    = vals.pop_front();
                void'(due.pop_front());
            end
            if (bus.pushout && !bus.stopin) begin
                checks++; if (bus.r !== 64'(nexp)) begin fails++; $display("FAIL wrap_order: got %0d expected %0d", bus.r, nexp); end
                nexp++;
            end
            step();
            cyc++;
        end
        bus.mul_pushin = 1'b0;
        bus.mul_push   = 1'b0;
        bus.stopin     = 1'b0;
        checks++; if (nexp != 40) begin fails++; $display("FAIL wrap_count: got %0d expected 40", nexp); end
        checks++; if (credit_err !== 1'b0) begin fails++; $display("FAIL wrap_credit_err: got %b expected 0", credit_err); end
        checks++; if (bus.pushout !== 1'b0) begin fails++; $display("FAIL wrap_empty: got %b expected 0", bus.pushout); end
    endtask

    task automatic test_errors();
        checks++; if (credit_err !== 1'b0) begin fails++; $display("FAIL err_before: got %b expected 0", credit_err); end
        bus.mul_push = 1'b1;
        bus.mul_r    = 64'h1234;
        bus.stopin   = 1'b1;
        step();
        bus.mul_push = 1'b0;
        checks++; if (credit_err !== 1'b1) begin fails++; $display("FAIL err_unexpected_push: got %b expected 1", credit_err); end
        checks++; if (bus.r !== 64'h1234) begin fails++; $display("FAIL err_data_kept: got %h expected 1234", bus.r); end
        bus.stopin = 1'b0;
        step();
        checks++; if (bus.pushout !== 1'b0) begin fails++; $display("FAIL err_drain: got %b expected 0", bus.pushout); end
        checks++; if (credit_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b expected 1", credit_err); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (credit_err !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b expected 0", credit_err); end
        checks++; if (bus.issue_ok !== 1'b1) begin fails++; $display("FAIL err_issue_ok: got %b expected 1", bus.issue_ok); end
    endtask

    task automatic test_full_simultaneous();
        bus.stopin = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.mul_pushin = 1'b1;
            step();
        end
        bus.mul_pushin = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.mul_push = 1'b1;
            bus.mul_r    = 64'(200 + i);
            step();
        end
        bus.mul_push   = 1'b0;
        bus.mul_pushin = 1'b1;
        step();
        bus.mul_pushin = 1'b0;
        checks++; if (credit_err !== 1'b1) begin fails++; $display("FAIL full_overissue_err: got %b expected 1", credit_err); end
        checks++; if (bus.issue_ok !== 1'b0) begin fails++; $display("FAIL full_issue_ok: got %b expected 0", bus.issue_ok); end
        bus.stopin   = 1'b0;
        bus.mul_push = 1'b1;
        bus.mul_r    = 64'hDEAD;
        step();
        bus.mul_push = 1'b0;
        bus.stopin   = 1'b1;
        checks++; if (bus.issue_ok !== 1'b0) begin fails++; $display("FAIL full_still_full: got %b expected 0", bus.issue_ok); end
        for (int i = 0; i < DEPTH; i++) begin
            logic [63:0] exp_v;
            exp_v = (i < DEPTH - 1) ? 64'(201 + i) : 64'hDEAD;
            checks++; if (bus.r !== exp_v) begin fails++; $display("FAIL full_order_%0d: got %h expected %h", i, bus.r, exp_v); end
            bus.stopin = 1'b0;
            step();
        end
        checks++; if (bus.pushout !== 1'b0) begin fails++; $display("FAIL full_empty: got %b expected 0", bus.pushout); end
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_credit_exhaustion();
        test_wrap_order();
        test_errors();
        test_full_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
